// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC/next-PC pair with branch-delay-slot semantics, one Avalon word read per instruction.
// Optional misaligned-fetch trap is compiled in with `define IFETCH_ALIGN_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  dest,
  output logic        active,
  output logic        fault,
  output logic [2:0]  state_dbg
);

  // Handshakes: a read is accepted in a cycle where read=1 and waitrequest=0, and
  // readdata is valid exactly one cycle later; an instruction is consumed in a
  // cycle where instr_valid=1 and stall_in=0, and nothing else counts as a transfer.

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_WAIT_DATA = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_HALTED    = 3'd3;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam logic [2:0] S_FAULT     = 3'd4;
`endif

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        consume;

  assign consume   = (state == S_ISSUE) && !stall_in;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (!waitrequest) state_next = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        // npc becomes the new pc on consume; halt at address 0 outranks the alignment trap
        if (!stall_in) begin
          if (npc == 32'd0) begin
            state_next = S_HALTED;
`ifdef IFETCH_ALIGN_CHECK_EN
          end else if (npc[1:0] != 2'b00) begin
            state_next = S_FAULT;
`endif
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        state_next = S_HALTED;
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      S_FAULT: begin
        state_next = S_FAULT;
      end
`endif
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  always_comb begin
    read        = 1'b0;
    active      = 1'b0;
    instr_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    fault       = 1'b0;
`endif
    if (!reset) begin
      case (state)
        S_FETCH: begin
          read   = 1'b1;
          active = 1'b1;
        end
        S_WAIT_DATA: begin
          active = 1'b1;
        end
        S_ISSUE: begin
          active      = 1'b1;
          instr_valid = 1'b1;
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        S_FAULT: begin
          fault = 1'b1;
        end
`endif
        default: begin
          read = 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  assign address = pc;
`else
  assign address = {pc[31:2], 2'b00};
  assign fault   = 1'b0;
`endif

  // Redirects land in npc only, so the delay-slot instruction at the old npc always issues first
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      npc      <= RESET_VECTOR + 32'd4;
      instr    <= 32'd0;
      instr_pc <= 32'd0;
    end else begin
      if (state == S_WAIT_DATA) begin
        instr    <= readdata;
        instr_pc <= pc;
      end
      if (consume) begin
        pc  <= npc;
        npc <= redirect_valid ? redirect_target : npc + 32'd4;
      end
    end
  end

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign dest  = instr[20:16];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multi-cycle MIPS CPU, directly upstream of the main decoder. Holds the PC/next-PC pair for MIPS branch-delay-slot semantics and issues one Avalon-style word read per instruction. Presents the fetched word and its decoder fields (`op`, `funct`, `dest`) under a valid/stall handshake, and halts the core when execution reaches address 0.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC00000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `address`  out  32  fetch byte address.
- `read`  out  1  read request.
- `waitrequest`  in  1  bus stall; request is held while high.
- `readdata`  in  32  instruction word, valid the cycle after acceptance.
- `stall_in`  in  1  downstream not ready to consume.
- `redirect_valid`  in  1  branch/jump taken, sampled on consume cycle only.
- `redirect_target`  in  32  target byte address.
- `instr_valid`  out  1  `instr`/fields valid.
- `instr`  out  32  fetched word.
- `instr_pc`  out  32  address of `instr`.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `dest`  out  5  `instr[20:16]` (rt; REGIMM selector).
- `active`  out  1  high while executing.
- `fault`  out  1  misaligned fetch (see Configuration).

## Operation
- Registers: `pc`, `npc`, `instr`, state. FSM: FETCH, WAIT_DATA, ISSUE, HALTED (plus FAULT when macro enabled).
- FETCH: `read`=1, `address`=`pc`. Stays while `waitrequest`=1; address and read held stable. On `waitrequest`=0 (accept) -> WAIT_DATA.
- WAIT_DATA: `read`=0; `instr`<=`readdata`, `instr_pc`<=`pc` -> ISSUE.
- ISSUE: `instr_valid`=1. While `stall_in`=1 all outputs held. Consume = `instr_valid & !stall_in`: `pc`<=`npc`; `npc`<=`redirect_valid ? redirect_target : npc+4`. Next state HALTED if new `pc`==0, else FETCH.
- Delay slot: the instruction after a branch is always fetched and issued before the target; redirect is applied to `npc`, never `pc`.
- HALTED: `active`=0, `read`=0, `instr_valid`=0; leaves only by reset. `redirect_valid` ignored.
- Redirect outside consume cycle ignored. PC arithmetic is modulo 2^32 (0xFFFFFFFC+4 = 0).
- One outstanding read maximum.

## Timing
- Reset values: `pc`=`RESET_VECTOR`, `npc`=`RESET_VECTOR`+4, state FETCH, `read`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `active`=0, `fault`=0. `read` and `active` held low during any reset cycle.
- First cycle after reset deasserted: `read`=1, `address`=`RESET_VECTOR`, `active`=1.
- Accept at cycle N, data at N+1, `instr_valid` at N+2. Minimum 3 cycles per instruction with `waitrequest`=0.
- Consume cycle C: next `read` at C+1.
- Reset mid-read or mid-stall: outstanding read abandoned, returning `readdata` ignored, state reinitialised next edge.
- Reset and consume in the same cycle: reset wins.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined: if the new `pc` has `pc[1:0]`≠0 at consume, enter FAULT instead of FETCH: `fault`=1, `active`=0, `read`=0, no further fetches until reset. Halt at address 0 takes priority.
- Undefined: no check; `address[1:0]` forced to 0, `fault` tied 0, FAULT state absent.

## Test plan
- Reset then `waitrequest`=0, no stall: reads at 0xBFC00000, 0xBFC00004, 0xBFC00008; each `instr_valid` exactly 2 cycles after acceptance, `op`/`funct`/`dest` match word fields.
- `waitrequest` high 4 cycles on first read: `read`=1, `address`=0xBFC00000 stable all 4 cycles; one accept only.
- Consume at 0xBFC00010 with `redirect_valid`=1, target 0xBFC00100: next fetches 0xBFC00014 (delay slot), then 0xBFC00100.
- Jump to 0 (`redirect_target`=0): delay slot issued, then `active` falls, `read` stays 0, no fetch at 0x00000000.
- `stall_in`=1 for 3 cycles in ISSUE with `redirect_valid` toggling: outputs held, redirect only taken on the consume cycle.
- Macro on, target 0xBFC00102: delay slot issued, then `fault`=1, `active`=0; macro off: read issued at 0xBFC00100.
